// File: rtl/pipecomp.sv
`default_nettype none
// ==========================================================================
// Module  : pipecomp (with instruction ROM pipecomp_im)
// Purpose : 5-stage pipelined MIPS-subset computer with forwarding/stall/flush
// Revision: 1.0
// ==========================================================================
module pipecomp_im #(
  parameter int IM_DEPTH = 128
) (
  input  logic [$clog2(IM_DEPTH)-1:0] i_addr,
  output logic [31:0]                 o_data
);
  logic [31:0] ROM [IM_DEPTH];
  assign o_data = ROM[i_addr];
endmodule

module pipecomp #(
  parameter int IM_DEPTH = 128,
  parameter int DM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DM_DEPTH);

  localparam logic [5:0] c_OP_RTYPE = 6'h00, c_OP_J  = 6'h02, c_OP_BEQ = 6'h04,
                         c_OP_ADDI  = 6'h08, c_OP_ORI = 6'h0D, c_OP_LW = 6'h23,
                         c_OP_SW    = 6'h2B;
  localparam logic [2:0] c_ALU_ADD = 3'd0, c_ALU_SUB = 3'd1, c_ALU_AND = 3'd2,
                         c_ALU_OR  = 3'd3, c_ALU_SLT = 3'd4;

  logic [31:0] r_pc, r_ifid_instr, r_ifid_pc4;
  logic [31:0] r_idex_pc4, r_idex_a, r_idex_b, r_idex_imm;
  logic [4:0]  r_idex_rs, r_idex_rt, r_idex_dst;
  logic        r_idex_regwr, r_idex_memrd, r_idex_memwr, r_idex_branch, r_idex_alusrc;
  logic [2:0]  r_idex_aluop;
  logic [31:0] r_exmem_alu, r_exmem_sdata;
  logic [4:0]  r_exmem_dst;
  logic        r_exmem_regwr, r_exmem_memrd, r_exmem_memwr;
  logic [31:0] r_memwb_res;
  logic [4:0]  r_memwb_dst;
  logic        r_memwb_regwr;
  logic [31:0] r_rf [32];
  logic [31:0] r_dm [DM_DEPTH];

  logic [31:0] w_if_instr, w_pc4;
  logic [5:0]  w_id_op;
  logic [4:0]  w_id_rs, w_id_rt, w_id_rd;
  logic [31:0] w_rd1, w_rd2, w_j_target;
  logic        w_dec_regwr, w_dec_memrd, w_dec_memwr, w_dec_branch, w_dec_alusrc, w_dec_jump;
  logic [2:0]  w_dec_aluop;
  logic [4:0]  w_dec_dst;
  logic [31:0] w_dec_imm;
  logic        w_stall, w_br_taken;
  logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu, w_br_target, w_dm_rdata, w_mem_res;

  // ---------------- IF ----------------
  pipecomp_im #(.IM_DEPTH(IM_DEPTH)) U_IM (
    .i_addr (r_pc[IM_AW+1:2]),
    .o_data (w_if_instr)
  );
  assign w_pc4 = r_pc + 32'd4;

  // ---------------- ID ----------------
  assign w_id_op    = r_ifid_instr[31:26];
  assign w_id_rs    = r_ifid_instr[25:21];
  assign w_id_rt    = r_ifid_instr[20:16];
  assign w_id_rd    = r_ifid_instr[15:11];
  assign w_j_target = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};

  // WB result is visible to ID in the same cycle it is written
  assign w_rd1 = (w_id_rs == 5'd0) ? 32'd0 :
                 (r_memwb_regwr && r_memwb_dst == w_id_rs) ? r_memwb_res : r_rf[w_id_rs];
  assign w_rd2 = (w_id_rt == 5'd0) ? 32'd0 :
                 (r_memwb_regwr && r_memwb_dst == w_id_rt) ? r_memwb_res : r_rf[w_id_rt];

  always_comb begin
    w_dec_regwr  = 1'b0;
    w_dec_memrd  = 1'b0;
    w_dec_memwr  = 1'b0;
    w_dec_branch = 1'b0;
    w_dec_alusrc = 1'b0;
    w_dec_jump   = 1'b0;
    w_dec_aluop  = c_ALU_ADD;
    w_dec_dst    = w_id_rt;
    w_dec_imm    = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
    case (w_id_op)
      c_OP_RTYPE: begin
        w_dec_dst   = w_id_rd;
        w_dec_regwr = 1'b1;
        case (r_ifid_instr[5:0])
          6'h20, 6'h21: w_dec_aluop = c_ALU_ADD;
          6'h22, 6'h23: w_dec_aluop = c_ALU_SUB;
          6'h24:        w_dec_aluop = c_ALU_AND;
          6'h25:        w_dec_aluop = c_ALU_OR;
          6'h2A:        w_dec_aluop = c_ALU_SLT;
          default:      w_dec_regwr = 1'b0;
        endcase
      end
      c_OP_ADDI: begin
        w_dec_regwr  = 1'b1;
        w_dec_alusrc = 1'b1;
      end
      c_OP_ORI: begin
        w_dec_regwr  = 1'b1;
        w_dec_alusrc = 1'b1;
        w_dec_aluop  = c_ALU_OR;
        w_dec_imm    = {16'd0, r_ifid_instr[15:0]};
      end
      c_OP_LW: begin
        w_dec_regwr  = 1'b1;
        w_dec_alusrc = 1'b1;
        w_dec_memrd  = 1'b1;
      end
      c_OP_SW: begin
        w_dec_alusrc = 1'b1;
        w_dec_memwr  = 1'b1;
      end
      c_OP_BEQ: w_dec_branch = 1'b1;
      c_OP_J:   w_dec_jump   = 1'b1;
      default:  ;
    endcase
  end

  assign w_stall = r_idex_memrd && (r_idex_rt != 5'd0) &&
                   ((r_idex_rt == w_id_rs) || (r_idex_rt == w_id_rt));

  // ---------------- EX ----------------
  always_comb begin
    w_fwd_a = r_idex_a;
    if (r_exmem_regwr && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rs)
      w_fwd_a = r_exmem_alu;
    else if (r_memwb_regwr && r_memwb_dst != 5'd0 && r_memwb_dst == r_idex_rs)
      w_fwd_a = r_memwb_res;
    w_fwd_b = r_idex_b;
    if (r_exmem_regwr && r_exmem_dst != 5'd0 && r_exmem_dst == r_idex_rt)
      w_fwd_b = r_exmem_alu;
    else if (r_memwb_regwr && r_memwb_dst != 5'd0 && r_memwb_dst == r_idex_rt)
      w_fwd_b = r_memwb_res;
  end

  assign w_alu_b = r_idex_alusrc ? r_idex_imm : w_fwd_b;

  always_comb begin
    case (r_idex_aluop)
      c_ALU_SUB: w_alu = w_fwd_a - w_alu_b;
      c_ALU_AND: w_alu = w_fwd_a & w_alu_b;
      c_ALU_OR:  w_alu = w_fwd_a | w_alu_b;
      c_ALU_SLT: w_alu = {31'd0, ($signed(w_fwd_a) < $signed(w_alu_b))};
      default:   w_alu = w_fwd_a + w_alu_b;
    endcase
  end

  assign w_br_taken  = r_idex_branch && (w_fwd_a == w_fwd_b);
  assign w_br_target = r_idex_pc4 + {r_idex_imm[29:0], 2'b00};

  // ---------------- MEM ----------------
  assign w_dm_rdata = r_dm[r_exmem_alu[DM_AW+1:2]];
  assign w_mem_res  = r_exmem_memrd ? w_dm_rdata : r_exmem_alu;

  // ---------------- State ----------------
  always_ff @(posedge clk) begin
    if (rstn || w_br_taken) begin
      r_pc         <= rstn ? 32'd0 : w_br_target;
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
    end else if (!w_stall) begin
      if (w_dec_jump) begin
        r_pc         <= w_j_target;
        r_ifid_instr <= 32'd0;
        r_ifid_pc4   <= 32'd0;
      end else begin
        r_pc         <= w_pc4;
        r_ifid_instr <= w_if_instr;
        r_ifid_pc4   <= w_pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn || w_br_taken || w_stall) begin
      r_idex_pc4    <= 32'd0;
      r_idex_a      <= 32'd0;
      r_idex_b      <= 32'd0;
      r_idex_imm    <= 32'd0;
      r_idex_rs     <= 5'd0;
      r_idex_rt     <= 5'd0;
      r_idex_dst    <= 5'd0;
      r_idex_regwr  <= 1'b0;
      r_idex_memrd  <= 1'b0;
      r_idex_memwr  <= 1'b0;
      r_idex_branch <= 1'b0;
      r_idex_alusrc <= 1'b0;
      r_idex_aluop  <= c_ALU_ADD;
    end else begin
      r_idex_pc4    <= r_ifid_pc4;
      r_idex_a      <= w_rd1;
      r_idex_b      <= w_rd2;
      r_idex_imm    <= w_dec_imm;
      r_idex_rs     <= w_id_rs;
      r_idex_rt     <= w_id_rt;
      r_idex_dst    <= w_dec_dst;
      r_idex_regwr  <= w_dec_regwr;
      r_idex_memrd  <= w_dec_memrd;
      r_idex_memwr  <= w_dec_memwr;
      r_idex_branch <= w_dec_branch;
      r_idex_alusrc <= w_dec_alusrc;
      r_idex_aluop  <= w_dec_aluop;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_exmem_alu   <= 32'd0;
      r_exmem_sdata <= 32'd0;
      r_exmem_dst   <= 5'd0;
      r_exmem_regwr <= 1'b0;
      r_exmem_memrd <= 1'b0;
      r_exmem_memwr <= 1'b0;
      r_memwb_res   <= 32'd0;
      r_memwb_dst   <= 5'd0;
      r_memwb_regwr <= 1'b0;
    end else begin
      r_exmem_alu   <= w_alu;
      r_exmem_sdata <= w_fwd_b;
      r_exmem_dst   <= r_idex_dst;
      r_exmem_regwr <= r_idex_regwr;
      r_exmem_memrd <= r_idex_memrd;
      r_exmem_memwr <= r_idex_memwr;
      r_memwb_res   <= w_mem_res;
      r_memwb_dst   <= r_exmem_dst;
      r_memwb_regwr <= r_exmem_regwr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn && r_exmem_memwr)
      r_dm[r_exmem_alu[DM_AW+1:2]] <= r_exmem_sdata;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 32; i++)
        r_rf[i] <= 32'd0;
    end else if (r_memwb_regwr && r_memwb_dst != 5'd0) begin
      r_rf[r_memwb_dst] <= r_memwb_res;
    end
  end

  assign reg_data = (reg_sel == 5'd0) ? 32'd0 : r_rf[reg_sel];

endmodule
`default_nettype wire

// File: tb/tb_pipecomp.sv
`default_nettype none
// ==========================================================================
// Module  : tb_pipecomp
// Purpose : directed programs with a register-expectation scoreboard
// Revision: 1.0
// ==========================================================================
module tb_pipecomp;
  localparam int IM_DEPTH = 128;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          at;
    logic [4:0]  sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];

  pipecomp #(.IM_DEPTH(IM_DEPTH), .DM_DEPTH(128)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_reg(input string tag, input int at, input logic [4:0] sel,
                            input logic [31:0] val);
    exp_t x;
    x.tag = tag;
    x.at  = at;
    x.sel = sel;
    x.val = val;
    sb.push_back(x);
  endtask

  // Hold reset for two edges while the ROM is reloaded with prog
  task automatic load_and_reset();
    rstn = 1'b1;
    for (int i = 0; i < IM_DEPTH; i++) dut.U_IM.ROM[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.U_IM.ROM[i] = prog[i];
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rstn = 1'b0;
  endtask

  // Edge e counts rising edges after reset release; expectations pop in order
  task automatic run(input string name, input int n_edges);
    exp_t x;
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) check({name, "_first_fetch"}, dut.r_ifid_instr, prog[0]);
      while (sb.size() > 0 && sb[0].at == e) begin
        x = sb.pop_front();
        reg_sel = x.sel;
        #1;
        check(x.tag, reg_data, x.val);
      end
    end
    check({name, "_sb_leftover"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    // Forwarding: addi $1,5; addi $2,3; add $3,$1,$2; sub $4,$3,$1
    prog = '{32'h20010005, 32'h20020003, 32'h00221820, 32'h00612022};
    load_and_reset();
    check("rst_pc", dut.r_pc, 32'd0);
    release_reset();
    expect_reg("fwd_r1",        5, 5'd1, 32'd5);
    expect_reg("fwd_r2",        6, 5'd2, 32'd3);
    expect_reg("fwd_r3_early",  6, 5'd3, 32'd0);
    expect_reg("fwd_r3",        7, 5'd3, 32'd8);
    expect_reg("fwd_r4_early",  7, 5'd4, 32'd0);
    expect_reg("fwd_r4",        8, 5'd4, 32'd3);
    run("fwd", 12);

    // Load-use: addi $5,0x2A; sw $5,8($0); lw $6,8($0); add $7,$6,$6
    prog = '{32'h2005002A, 32'hAC050008, 32'h8C060008, 32'h00C63820};
    load_and_reset();
    check("rst_pc2", dut.r_pc, 32'd0);
    for (int s = 0; s < 32; s++) begin
      reg_sel = 5'(s);
      #1;
      check($sformatf("rst_reg%0d", s), reg_data, 32'd0);
    end
    release_reset();
    expect_reg("lu_r5",       5, 5'd5, 32'h2A);
    expect_reg("lu_r6",       7, 5'd6, 32'h2A);
    expect_reg("lu_r7_early", 8, 5'd7, 32'h0);
    expect_reg("lu_r7",       9, 5'd7, 32'h54);
    run("lu", 12);

    // Branch taken: beq $0,$0,+2; addi $8,1; addi $9,1; addi $10,7
    prog = '{32'h10000002, 32'h20080001, 32'h20090001, 32'h200A0007};
    load_and_reset();
    release_reset();
    expect_reg("br_r10_early", 7, 5'd10, 32'd0);
    expect_reg("br_r10",       8, 5'd10, 32'd7);
    expect_reg("br_r8",       10, 5'd8,  32'd0);
    expect_reg("br_r9",       10, 5'd9,  32'd0);
    run("br", 12);

    // Loop: $7 counts to $11=10 via beq exit / j top, then spins on j
    prog = '{32'h20070000, 32'h200B000A, 32'h10EB0002, 32'h20E70001,
             32'h08000002, 32'h08000005};
    load_and_reset();
    release_reset();
    expect_reg("loop_r11", 150, 5'd11, 32'd10);
    expect_reg("loop_r7",  150, 5'd7,  32'd10);
    run("loop", 160);

    // $0 protection plus addi sign-ext, ori zero-ext, signed slt, and
    prog = '{32'h20000009, 32'h00006020, 32'h200DFFFF, 32'h340EFFFF,
             32'h01A0782A, 32'h01AE8024};
    load_and_reset();
    release_reset();
    expect_reg("z_r0",  11, 5'd0,  32'd0);
    expect_reg("z_r12", 11, 5'd12, 32'd0);
    expect_reg("z_r13", 11, 5'd13, 32'hFFFFFFFF);
    expect_reg("z_r14", 11, 5'd14, 32'h0000FFFF);
    expect_reg("z_r15", 11, 5'd15, 32'd1);
    expect_reg("z_r16", 11, 5'd16, 32'h0000FFFF);
    run("zero", 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
